// File: rtl/hex_display_ctrl.sv
// hex_display_ctrl: latches a 32-bit word, decodes it one nibble per cycle, then commits all 8 digits at once.
// Latency: 10 cycles strobe-to-display (8 CONV + 1 COMMIT + output register); one word per 10 cycles.
// Backpressure: none; data_we while busy is dropped and flagged on sticky overrun. Blink built with HEXDISP_BLINK_EN.
module hex_display_ctrl #(
    parameter int BLINK_DIV = 25_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic        data_we,
    input  logic        lz_en,
    input  logic        blink,
    output logic        busy,
    output logic        done,
    output logic        overrun,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7
);
    typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

    state_t      state, state_nxt;
    logic [31:0] word_q;
    logic        lz_q;
    logic        lead_q;
    logic [2:0]  idx_q;
    logic [6:0]  stage_q [8];
    logic [6:0]  disp_q  [8];
    logic [6:0]  hex_q   [8];
    logic [3:0]  nib;
    logic [6:0]  seg;
    logic        blank_dig;
    logic        is_commit;

    function automatic logic [6:0] decode(input logic [3:0] n);
        case (n)
            4'h0: decode = 7'h40;  4'h1: decode = 7'h79;
            4'h2: decode = 7'h24;  4'h3: decode = 7'h30;
            4'h4: decode = 7'h19;  4'h5: decode = 7'h12;
            4'h6: decode = 7'h02;  4'h7: decode = 7'h78;
            4'h8: decode = 7'h00;  4'h9: decode = 7'h10;
            4'hA: decode = 7'h08;  4'hB: decode = 7'h03;
            4'hC: decode = 7'h46;  4'hD: decode = 7'h21;
            4'hE: decode = 7'h06;  default: decode = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (data_we) state_nxt = CONV;
            CONV:    if (idx_q == 3'd0) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        is_commit = (state == COMMIT);
    end

    // Single shared decoder walks the latched word from digit 7 down to 0.
    assign nib       = word_q[{idx_q, 2'b00} +: 4];
    assign seg       = decode(nib);
    assign blank_dig = lz_q && lead_q && (nib == 4'h0) && (idx_q != 3'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            word_q  <= '0;
            lz_q    <= 1'b0;
            lead_q  <= 1'b0;
            idx_q   <= '0;
            done    <= 1'b0;
            overrun <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                stage_q[k] <= 7'h7F;
                disp_q[k]  <= 7'h7F;
            end
        end else begin
            done <= is_commit;
            if (data_we && busy) overrun <= 1'b1;
            case (state)
                IDLE: if (data_we) begin
                    word_q <= data_in;
                    lz_q   <= lz_en;
                    idx_q  <= 3'd7;
                    lead_q <= 1'b1;
                end
                CONV: begin
                    if (blank_dig) begin
                        stage_q[idx_q] <= 7'h7F;
                    end else begin
                        stage_q[idx_q] <= seg;
                        lead_q         <= 1'b0;
                    end
                    idx_q <= idx_q - 3'd1;
                end
                COMMIT: for (int k = 0; k < 8; k++) disp_q[k] <= stage_q[k];
                default: ;
            endcase
        end
    end

`ifdef HEXDISP_BLINK_EN
    localparam int CW = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;

    logic [CW-1:0] blink_cnt;
    logic          hidden_q;
    logic [6:0]    out_q [8];

    // Outputs are registered so blink never reaches the pins combinationally.
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            hidden_q  <= 1'b0;
            for (int k = 0; k < 8; k++) out_q[k] <= 7'h7F;
        end else begin
            if (blink_cnt == CW'(BLINK_DIV - 1)) begin
                blink_cnt <= '0;
                hidden_q  <= ~hidden_q;
            end else begin
                blink_cnt <= blink_cnt + CW'(1);
            end
            for (int k = 0; k < 8; k++)
                out_q[k] <= (blink && hidden_q) ? 7'h7F : (is_commit ? stage_q[k] : disp_q[k]);
        end
    end

    always_comb for (int k = 0; k < 8; k++) hex_q[k] = out_q[k];
`else
    localparam int unused_blink_div = BLINK_DIV;
    logic unused_blink;
    assign unused_blink = blink;

    always_comb for (int k = 0; k < 8; k++) hex_q[k] = disp_q[k];
`endif

    assign hex0 = hex_q[0];
    assign hex1 = hex_q[1];
    assign hex2 = hex_q[2];
    assign hex3 = hex_q[3];
    assign hex4 = hex_q[4];
    assign hex5 = hex_q[5];
    assign hex6 = hex_q[6];
    assign hex7 = hex_q[7];

endmodule

// File: tb/tb_hex_display_ctrl.sv
// Bench for hex_display_ctrl: spec vectors from a table, random words against an arithmetic reference,
// plus hand sequences for overrun, mid-conversion reset, back-to-back accept and (optionally) blink.
module tb_hex_display_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic        data_we;
    logic        lz_en;
    logic        blink;
    logic        busy, done, overrun;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7;
    logic [55:0] hex_all;

    int total = 0;
    int bad   = 0;

    logic [6:0] seg_tab [16];

    typedef struct {
        logic [31:0] w;
        logic        lz;
        logic [55:0] exp;
    } vec_t;

    vec_t vecs [6];

    hex_display_ctrl #(.BLINK_DIV(4)) dut (
        .clk(clk), .rst(rst), .data_in(data_in), .data_we(data_we),
        .lz_en(lz_en), .blink(blink), .busy(busy), .done(done), .overrun(overrun),
        .hex0(hex0), .hex1(hex1), .hex2(hex2), .hex3(hex3),
        .hex4(hex4), .hex5(hex5), .hex6(hex6), .hex7(hex7)
    );

    always #5 clk = ~clk;

    assign hex_all = {hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Digit k is blank when blanking is on, k > 0 and the word has nothing at or above nibble k.
    function automatic logic [55:0] model(input logic [31:0] w, input logic lz);
        logic [55:0] r;
        r = '0;
        for (int k = 0; k < 8; k++) begin
            if (lz && k != 0 && (w >> (4 * k)) == 32'd0)
                r[7*k +: 7] = 7'h7F;
            else
                r[7*k +: 7] = seg_tab[(w >> (4 * k)) & 32'hF];
        end
        return r;
    endfunction

    // Strobe at T, then follow T+1..T+11 checking busy length, done timing and the committed digits.
    task automatic run_word(input string name, input logic [31:0] w, input logic lz, input logic [55:0] exp);
        int busy_cnt;
        int early_done;
        data_in = w;
        lz_en   = lz;
        data_we = 1'b1;
        step();
        data_we    = 1'b0;
        busy_cnt   = 0;
        early_done = 0;
        for (int i = 1; i <= 9; i++) begin
            if (busy) busy_cnt++;
            if (done) early_done++;
            step();
        end
        check({name, " busy_len"}, 64'(busy_cnt), 64'd9);
        check({name, " early_done"}, 64'(early_done), 64'd0);
        check({name, " done"}, 64'(done), 64'd1);
        check({name, " busy_end"}, 64'(busy), 64'd0);
        check({name, " hex"}, 64'(hex_all), 64'(exp));
        step();
        check({name, " done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int dones;
        logic [31:0] w;
        logic lz;

        seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

        vecs[0] = '{32'h0018_4135, 1'b1, {7'h7F, 7'h7F, 7'h79, 7'h00, 7'h19, 7'h79, 7'h30, 7'h12}};
        vecs[1] = '{32'h0018_4135, 1'b0, {7'h40, 7'h40, 7'h79, 7'h00, 7'h19, 7'h79, 7'h30, 7'h12}};
        vecs[2] = '{32'h0000_0000, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{32'hDEAD_BEEF, 1'b1, {7'h21, 7'h06, 7'h08, 7'h21, 7'h03, 7'h06, 7'h06, 7'h0E}};
        vecs[4] = '{32'h1000_0000, 1'b1, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{32'h0000_0F00, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h0E, 7'h40, 7'h40}};

        rst = 1'b1; data_in = '0; data_we = 1'b0; lz_en = 1'b0; blink = 1'b0;
        step(); step();
        rst = 1'b0;
        check("reset hex", 64'(hex_all), {8'h0, {8{7'h7F}}});
        check("reset busy", 64'(busy), 64'd0);
        check("reset done", 64'(done), 64'd0);
        check("reset overrun", 64'(overrun), 64'd0);

        for (int i = 0; i < 6; i++) run_word($sformatf("vec%0d", i), vecs[i].w, vecs[i].lz, vecs[i].exp);

        for (int i = 0; i < 20; i++) begin
            w  = $urandom >> $urandom_range(0, 31);
            lz = 1'($urandom_range(0, 1));
            run_word($sformatf("rand%0d", i), w, lz, model(w, lz));
        end

        // Overrun: second strobe at T+3 is dropped.
        check("ovr before", 64'(overrun), 64'd0);
        data_in = 32'h1234_5678; lz_en = 1'b0; data_we = 1'b1;
        step();
        data_we = 1'b0;
        step(); step();
        data_in = 32'h0; lz_en = 1'b1; data_we = 1'b1;
        step();
        data_we = 1'b0;
        check("ovr set", 64'(overrun), 64'd1);
        dones = 0;
        for (int i = 4; i <= 14; i++) begin
            if (done) dones++;
            step();
        end
        check("ovr dones", 64'(dones), 64'd1);
        check("ovr hex", 64'(hex_all), 64'(model(32'h1234_5678, 1'b0)));
        check("ovr sticky", 64'(overrun), 64'd1);

        // Back-to-back: a strobe in T+10 is accepted without overrun.
        rst = 1'b1; step(); rst = 1'b0;
        data_in = 32'hCAFE_0001; lz_en = 1'b0; data_we = 1'b1;
        step();
        data_we = 1'b0;
        for (int i = 1; i < 10; i++) step();
        check("b2b done", 64'(done), 64'd1);
        data_in = 32'h0000_00A5; lz_en = 1'b1; data_we = 1'b1;
        step();
        data_we = 1'b0;
        check("b2b accepted", 64'(busy), 64'd1);
        check("b2b no_overrun", 64'(overrun), 64'd0);
        for (int i = 1; i < 10; i++) step();
        check("b2b hex", 64'(hex_all), 64'(model(32'h0000_00A5, 1'b1)));

        // Reset at T+4 aborts the conversion.
        data_in = 32'h8765_4321; lz_en = 1'b0; data_we = 1'b1;
        step();
        data_we = 1'b0;
        step(); step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmid hex", 64'(hex_all), {8'h0, {8{7'h7F}}});
        check("rstmid busy", 64'(busy), 64'd0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            step();
        end
        check("rstmid no_done", 64'(dones), 64'd0);
        check("rstmid hex_hold", 64'(hex_all), {8'h0, {8{7'h7F}}});

        // Reset and strobe together: word dropped, no overrun.
        rst = 1'b1; data_in = 32'h5555_5555; data_we = 1'b1;
        step();
        rst = 1'b0; data_we = 1'b0;
        step();
        check("rstwe busy", 64'(busy), 64'd0);
        check("rstwe overrun", 64'(overrun), 64'd0);

`ifdef HEXDISP_BLINK_EN
        begin
            int n_hid, n_vis;
            run_word("blink_setup", 32'h0000_0001, 1'b1, model(32'h0000_0001, 1'b1));
            blink = 1'b1;
            step();
            n_hid = 0; n_vis = 0;
            for (int i = 0; i < 32; i++) begin
                if (hex0 == 7'h7F) n_hid++;
                if (hex0 == 7'h79) n_vis++;
                step();
            end
            check("blink hidden", 64'(n_hid), 64'd16);
            check("blink visible", 64'(n_vis), 64'd16);
            blink = 1'b0;
            step();
            check("blink off", 64'(hex0), 64'h79);
            step(); step(); step(); step(); step();
            check("blink hold", 64'(hex0), 64'h79);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_display_ctrl.md
# hex_display_ctrl

Downstream consumer of the CPU's 32-bit `gpio_out` word, replacing direct wiring to the eight seven-segment displays. On a write strobe it latches the word and decodes it serially through one shared nibble-to-segment decoder, one digit per cycle, into a staging buffer. It then commits all eight digits to HEX7..HEX0 in a single cycle, so a display never shows a half-updated value. Optional leading-zero blanking and an optional blink feature support the bin2dec BCD result display.

## Interface
- `BLINK_DIV`, default 25_000_000: cycles per blink half-period. Used only when `HEXDISP_BLINK_EN` is defined. Must be ≥ 2.
- `clk` in 1: system clock (CLOCK_50 domain).
- `rst` in 1: synchronous, active-high reset.
- `data_in` in 32: word to display. Nibble k drives HEXk.
- `data_we` in 1: write strobe, one cycle, sampled on the rising edge.
- `lz_en` in 1: leading-zero blanking enable. Sampled together with `data_in`.
- `blink` in 1: blink request. Ignored when the macro is absent.
- `busy` out 1: high while a conversion is in progress.
- `done` out 1: one-cycle pulse in the cycle new digits first appear.
- `overrun` out 1: sticky. Set when a `data_we` is dropped.
- `hex0`..`hex7` out 7 each: active-low segments, bit0 = a … bit6 = g.

## Operation
- States: IDLE, CONV, COMMIT.
- IDLE:
  - On `data_we`, latch `data_in` and `lz_en`.
  - Set digit index to 7 and the leading flag to 1.
  - Go to CONV.
- CONV, for each index from 7 down to 0 (one per cycle):
  - Take nibble n = latched[4*idx+3 : 4*idx].
  - If `lz_en` is set, the leading flag is 1, n == 0 and idx ≠ 0: stage blank (7'h7F).
  - Otherwise: stage decode(n) and clear the leading flag.
  - After idx 0, go to COMMIT.
- COMMIT:
  - Copy all 8 staged patterns to the `hex` output registers.
  - Go to IDLE.
- Decode table (n → pattern):
  - 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78
  - 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E
- `data_we` while `busy` is high:
  - The word is dropped and `overrun` is set to 1.
  - The conversion in flight is unaffected.
  - `overrun` clears only on `rst`.
- Digit 0 is never blanked, so a value of 0 displays as "0".

## Timing
- Reset values:
  - `hex0`..`hex7` = 7'h7F (all segments off).
  - `busy` = 0, `done` = 0, `overrun` = 0.
  - State = IDLE; staging buffer = 7'h7F for all digits.
  - Blink counter = 0, blink phase = visible.
- Conversion sequence for a `data_we` sampled at the end of cycle T:
  - `busy` is high in cycles T+1 through T+9.
  - CONV occupies T+1..T+8, handling digits 7..0.
  - COMMIT occupies T+9.
  - In cycle T+10: new `hex` values are visible, `done` = 1, `busy` = 0.
- Latency is 10 cycles from strobe to display.
- A new `data_we` in cycle T+10 is accepted. Maximum throughput is one word per 10 cycles.
- `rst` mid-conversion:
  - Aborts the conversion and restores all reset values on the next edge.
  - No `done` pulse occurs for the aborted word.
- `rst` and `data_we` in the same cycle: `rst` wins and the word is dropped. `overrun` is not set.
- Outputs change only on a COMMIT edge or a blink edge. There are no combinational paths from inputs to outputs.

## Configuration
- Macro `HEXDISP_BLINK_EN`.
- Defined:
  - A free-running counter from 0 to BLINK_DIV−1 toggles the blink phase on wrap.
  - While `blink` is 1 and the phase is "hidden", all `hex` outputs read 7'h7F. Otherwise they show the committed patterns.
  - Deasserting `blink` restores the display on the next edge.
  - Committed patterns are retained while hidden.
- Undefined:
  - No counter is built and `blink` is unused.
  - `hex` outputs always show the committed patterns.

## Test plan
- Blanked BCD result:
  - Stimulus: `data_in` = 0x00184135, `lz_en` = 1, strobe at T.
  - Required at T+10: hex7 = hex6 = 7F, hex5 = 79, hex4 = 00, hex3 = 19, hex2 = 79, hex1 = 30, hex0 = 12, `done` = 1.
  - Required throughout: `busy` high for exactly 9 cycles.
- Unblanked: same word with `lz_en` = 0 → hex7 = hex6 = 40, other digits as above.
- Zero and hex glyphs:
  - 0x00000000 with `lz_en` = 1 → hex0 = 40, hex7..hex1 = 7F.
  - Then 0xDEADBEEF → 21, 06, 08, 21, 03, 06, 06, 0E for hex7..hex0.
- Overrun: strobe 0x12345678, then strobe 0x0 at T+3 → display shows 12345678, `overrun` = 1, only one `done` pulse.
- Reset mid-operation: strobe at T, `rst` at T+4 → on the next cycle all `hex` = 7F, `busy` = 0; no `done` follows.
- Blink (`HEXDISP_BLINK_EN`, BLINK_DIV = 4): commit 0x00000001, then `blink` = 1 → hex0 alternates 79 / 7F every 4 cycles; `blink` = 0 → hex0 holds 79.
